centroid_divider: RTL and testbench



---
 rtl/centroid_pkg.sv | 32 +++
 rtl/restoring_div_step.sv | 24 ++
 rtl/centroid_divider.sv | 162 ++++++++++++++++
 tb/tb_centroid_divider.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared constants and types for the centroid divider.
// CENTROID_DIV_ROUND_EN widens each dividend by one bit for round-to-nearest.
package centroid_pkg;

  localparam int unsigned COORD_NUM        = 7;
  localparam int unsigned ACCUM_CORD_WIDTH = 22;
  localparam int unsigned COUNT_WIDTH      = 10;
  localparam int unsigned ACCUM_WIDTH      = COORD_NUM * ACCUM_CORD_WIDTH;
  localparam int unsigned REM_WIDTH        = COUNT_WIDTH + 1;
  localparam int unsigned SHIFT_WIDTH      = REM_WIDTH + 1;

`ifdef CENTROID_DIV_ROUND_EN
  localparam int unsigned DIV_WIDTH = ACCUM_CORD_WIDTH + 1;
`else
  localparam int unsigned DIV_WIDTH = ACCUM_CORD_WIDTH;
`endif

  localparam int unsigned COORD_IDX_WIDTH = $clog2(COORD_NUM);
  localparam int unsigned BIT_IDX_WIDTH   = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  typedef logic [ACCUM_CORD_WIDTH-1:0] accum_cord_t;
  typedef logic [DIV_WIDTH-1:0]        dividend_t;
  typedef logic [REM_WIDTH-1:0]        rem_t;
  typedef logic [COUNT_WIDTH-1:0]      count_t;

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module restoring_div_step
  import centroid_pkg::*;
(
  input  rem_t   rem_i,
  input  logic   dividend_bit_i,
  input  count_t divisor_i,
  output rem_t   rem_c_o,
  output logic   quot_bit_c_o
);

  logic [SHIFT_WIDTH-1:0] shifted_c;
  logic [SHIFT_WIDTH-1:0] divisor_ext_c;

  assign shifted_c     = {rem_i, dividend_bit_i};
  assign divisor_ext_c = SHIFT_WIDTH'(divisor_i);
  assign quot_bit_c_o  = (shifted_c >= divisor_ext_c);

  // Remainder stays below the divisor, so the difference always fits REM_WIDTH.
  assign rem_c_o = quot_bit_c_o ? REM_WIDTH'(shifted_c - divisor_ext_c)
                                : REM_WIDTH'(shifted_c);

endmodule

// File: rtl/centroid_divider.sv
// Serial centroid divider: divides 7 coordinate sums by the member count
// with one shared restoring step. CENTROID_DIV_ROUND_EN selects round-to-nearest.
module centroid_divider
  import centroid_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ACCUM_WIDTH-1:0]      accum_sums,
  input  logic [COUNT_WIDTH-1:0]      count,
  output logic                        busy,
  output logic                        done,
  output logic                        empty_cluster,
  output logic [ACCUM_CORD_WIDTH-1:0] result_cord_1,
  output logic [ACCUM_CORD_WIDTH-1:0] result_cord_2,
  output logic [ACCUM_CORD_WIDTH-1:0] result_cord_3,
  output logic [ACCUM_CORD_WIDTH-1:0] result_cord_4,
  output logic [ACCUM_CORD_WIDTH-1:0] result_cord_5,
  output logic [ACCUM_CORD_WIDTH-1:0] result_cord_6,
  output logic [ACCUM_CORD_WIDTH-1:0] result_cord_7
);

  state_t                     state_q,     state_d;
  logic [COORD_IDX_WIDTH-1:0] coord_idx_q, coord_idx_d;
  logic [BIT_IDX_WIDTH-1:0]   bit_idx_q,   bit_idx_d;
  rem_t                       rem_q,       rem_d;
  logic [DIV_WIDTH-2:0]       quot_q,      quot_d;
  count_t                     divisor_q,   divisor_d;
  dividend_t                  dividend_q [COORD_NUM];
  dividend_t                  dividend_d [COORD_NUM];
  accum_cord_t                result_q   [COORD_NUM];
  accum_cord_t                result_d   [COORD_NUM];
  logic                       busy_q,      busy_d;
  logic                       done_q,      done_d;
  logic                       empty_q,     empty_d;

  logic                       dividend_bit_c;
  rem_t                       rem_step_c;
  logic                       quot_bit_c;
  dividend_t                  quot_shift_c;

  assign dividend_bit_c = dividend_q[coord_idx_q][bit_idx_q];
  assign quot_shift_c   = {quot_q, quot_bit_c};

  restoring_div_step u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (dividend_bit_c),
    .divisor_i      (divisor_q),
    .rem_c_o        (rem_step_c),
    .quot_bit_c_o   (quot_bit_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      coord_idx_q <= '0;
      bit_idx_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      dividend_q  <= '{default: '0};
      result_q    <= '{default: '0};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      coord_idx_q <= coord_idx_d;
      bit_idx_q   <= bit_idx_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      divisor_q   <= divisor_d;
      dividend_q  <= dividend_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      empty_q     <= empty_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    coord_idx_d = coord_idx_q;
    bit_idx_d   = bit_idx_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    divisor_d   = divisor_q;
    dividend_d  = dividend_q;
    result_d    = result_q;
    empty_d     = empty_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < COORD_NUM; k++) begin
`ifdef CENTROID_DIV_ROUND_EN
            dividend_d[k] = DIV_WIDTH'(accum_sums[k*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH])
                          + DIV_WIDTH'(count >> 1);
`else
            dividend_d[k] = accum_sums[k*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH];
`endif
          end
          divisor_d   = count;
          coord_idx_d = '0;
          bit_idx_d   = BIT_IDX_WIDTH'(DIV_WIDTH - 1);
          rem_d       = '0;
          quot_d      = '0;
          result_d    = '{default: '0};
          empty_d     = (count == '0);
          state_d     = (count == '0) ? DONE : DIVIDE;
        end
      end

      DIVIDE: begin
        rem_d  = rem_step_c;
        quot_d = quot_shift_c[DIV_WIDTH-2:0];
        if (bit_idx_q == '0) begin
          // Rounded quotients provably fit, so truncation only drops a zero bit.
          result_d[coord_idx_q] = ACCUM_CORD_WIDTH'(quot_shift_c);
          rem_d     = '0;
          quot_d    = '0;
          bit_idx_d = BIT_IDX_WIDTH'(DIV_WIDTH - 1);
          if (coord_idx_q == COORD_IDX_WIDTH'(COORD_NUM - 1)) begin
            coord_idx_d = '0;
            state_d     = DONE;
          end else begin
            coord_idx_d = coord_idx_q + COORD_IDX_WIDTH'(1);
          end
        end else begin
          bit_idx_d = bit_idx_q - BIT_IDX_WIDTH'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DIVIDE);
    done_d = (state_d == DONE);
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign empty_cluster = empty_q;
  assign result_cord_1 = result_q[0];
  assign result_cord_2 = result_q[1];
  assign result_cord_3 = result_q[2];
  assign result_cord_4 = result_q[3];
  assign result_cord_5 = result_q[4];
  assign result_cord_6 = result_q[5];
  assign result_cord_7 = result_q[6];

endmodule

// File: tb/tb_centroid_divider.sv
// Scoreboard bench for centroid_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_centroid_divider;

  localparam int unsigned W  = 22;
  localparam int unsigned N  = 7;
  localparam int unsigned CW = 10;
`ifdef CENTROID_DIV_ROUND_EN
  localparam int unsigned STEPS = W + 1;
`else
  localparam int unsigned STEPS = W;
`endif
  localparam int unsigned LAT = N * STEPS + 1;

  typedef logic [N-1:0][W-1:0] vec_t;

  typedef struct packed {
    vec_t        res;
    logic        empty;
    logic [31:0] done_edge;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N*W-1:0] accum_sums;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          empty_cluster;
  logic [W-1:0]  r1, r2, r3, r4, r5, r6, r7;
  vec_t          dut_res;

  int unsigned   edges = 0;
  int            total = 0;
  int            bad   = 0;
  exp_t          q[$];
  exp_t          mon_e;

  assign dut_res = {r7, r6, r5, r4, r3, r2, r1};

  centroid_divider dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .accum_sums    (accum_sums),
    .count         (count),
    .busy          (busy),
    .done          (done),
    .empty_cluster (empty_cluster),
    .result_cord_1 (r1),
    .result_cord_2 (r2),
    .result_cord_3 (r3),
    .result_cord_4 (r4),
    .result_cord_5 (r5),
    .result_cord_6 (r6),
    .result_cord_7 (r7)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at edge %0d", name, act, exp, edges);
    end
  endtask

  // Reference: plain integer division (optionally rounded) per coordinate.
  function automatic vec_t ref_means(input vec_t sums, input logic [CW-1:0] cnt);
    vec_t r = '0;
    if (cnt != 0) begin
      for (int i = 0; i < N; i++) begin
        longint unsigned s;
        s = 64'(sums[i]);
`ifdef CENTROID_DIV_ROUND_EN
        s = s + 64'(cnt / 2);
`endif
        r[i] = W'(s / 64'(cnt));
      end
    end
    return r;
  endfunction

  function automatic vec_t splat(input logic [W-1:0] v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  function automatic vec_t rand_sums();
    vec_t r;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       r[i] = '0;
        1:       r[i] = {W{1'b1}};
        2:       r[i] = W'($urandom_range(0, 2000));
        default: r[i] = W'($urandom);
      endcase
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done at edge %0d", edges);
      end else begin
        mon_e = q.pop_front();
        check("done_cycle", (N*W)'(edges), (N*W)'(mon_e.done_edge));
        check("empty_cluster", (N*W)'(empty_cluster), (N*W)'(mon_e.empty));
        check("results", dut_res, mon_e.res);
        check("busy_at_done", (N*W)'(busy), '0);
      end
    end
  end

  task automatic issue(input vec_t sums, input logic [CW-1:0] cnt,
                       input vec_t exp_res, input logic exp_empty);
    exp_t e;
    accum_sums = sums;
    count      = cnt;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    accum_sums = {$urandom, $urandom, $urandom, $urandom, $urandom};
    count      = CW'($urandom);
    e.res       = exp_res;
    e.empty     = exp_empty;
    e.done_edge = edges + ((cnt == 0) ? 1 : LAT) - 1;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL job_timeout pending=%0d", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_job(input vec_t sums, input logic [CW-1:0] cnt);
    issue(sums, cnt, ref_means(sums, cnt), (cnt == 0));
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at edge %0d", edges);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t sums_a;
    vec_t exp_a;
    vec_t sums_d;
    vec_t exp_d;
    logic [CW-1:0] cnt;

    rst        = 1'b1;
    start      = 1'b0;
    accum_sums = '0;
    count      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  (N*W)'(busy), '0);
    check("reset_done",  (N*W)'(done), '0);
    check("reset_empty", (N*W)'(empty_cluster), '0);
    check("reset_res",   dut_res, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic: every mean is 100, busy spans cycles 1..LAT-1.
    issue(splat(W'(1000)), CW'(10), splat(W'(100)), 1'b0);
    check("busy_first", (N*W)'(busy), (N*W)'(1));
    repeat (LAT - 2) @(posedge clk);
    #1;
    check("busy_last", (N*W)'(busy), (N*W)'(1));
    @(posedge clk);
    #1;
    check("busy_after", (N*W)'(busy), '0);
    wait_idle();

    // Distinct coordinates with count 7.
    sums_d = {W'(999), W'(500), W'(4194303), W'(22), W'(7), W'(1), W'(0)};
`ifdef CENTROID_DIV_ROUND_EN
    exp_d  = {W'(143), W'(71), W'(599186), W'(3), W'(1), W'(0), W'(0)};
`else
    exp_d  = {W'(142), W'(71), W'(599186), W'(3), W'(1), W'(0), W'(0)};
`endif
    issue(sums_d, CW'(7), exp_d, 1'b0);
    wait_idle();

    // Empty cluster: done after one cycle, results zero, flag held.
    issue(splat(W'(12345)), CW'(0), '0, 1'b1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      check("empty_hold", (N*W)'(empty_cluster), (N*W)'(1));
      @(posedge clk);
      #1;
    end

    // Ignored second start mid-run, then results held while idle.
    sums_a = rand_sums();
    exp_a  = ref_means(sums_a, CW'(37));
    issue(sums_a, CW'(37), exp_a, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    accum_sums = {$urandom, $urandom, $urandom, $urandom, $urandom};
    count      = CW'(3);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ignored_start", (N*W)'(busy), (N*W)'(1));
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      check("hold_res", dut_res, exp_a);
      check("hold_empty", (N*W)'(empty_cluster), '0);
      @(posedge clk);
      #1;
    end

    // Reset mid-run with a competing start: reset must win.
    issue(rand_sums(), CW'(11), '0, 1'b0);
    repeat (78) @(posedge clk);
    #1;
    rst        = 1'b1;
    start      = 1'b1;
    count      = CW'(5);
    accum_sums = {$urandom, $urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    q.delete();
    check("abort_busy", (N*W)'(busy), '0);
    check("abort_done", (N*W)'(done), '0);
    check("abort_res",  dut_res, '0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_busy", (N*W)'(busy), '0);
    model_job(rand_sums(), CW'(513));

    // Rounding boundary around the half point.
`ifdef CENTROID_DIV_ROUND_EN
    issue(splat(W'(15)), CW'(10), splat(W'(2)), 1'b0);
    wait_idle();
    issue(splat(W'(14)), CW'(10), splat(W'(1)), 1'b0);
    wait_idle();
`else
    issue(splat(W'(15)), CW'(10), splat(W'(1)), 1'b0);
    wait_idle();
`endif
    issue(splat({W{1'b1}}), CW'(1), splat({W{1'b1}}), 1'b0);
    wait_idle();

    // Randomized jobs against the reference model.
    for (int j = 0; j < 25; j++) begin
      case ($urandom_range(0, 9))
        0:       cnt = '0;
        1:       cnt = CW'(1);
        2:       cnt = {CW{1'b1}};
        default: cnt = CW'($urandom_range(1, (1 << CW) - 1));
      endcase
      model_job(rand_sums(), cnt);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
